// File: rtl/wb_pkg.sv
// wb_pkg: shared constants, state type and lane-slice helper for the writeback stage
package wb_pkg;
  localparam logic [1:0] OPTYPE_VECTOR = 2'b01;
  localparam logic       WBSEL_MEM     = 1'b1;
  typedef enum logic {WB_IDLE, WB_BUSY} wb_state_t;
  function automatic int lane_base(input int beat, input int l);
    return beat * l;
  endfunction
endpackage

// File: rtl/wb_vector_writeback_if.sv
// wb_vector_writeback_if: MEM/WB register outputs in, scalar/vector RF write ports out
interface wb_vector_writeback_if #(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 4
);
  localparam int B  = V / L;
  localparam int BW = B > 1 ? $clog2(B) : 1;
  logic [3:0]          A3_i;
  logic [N-1:0]        Data_Mem_S_i;
  logic [N-1:0]        Data_Result_S_i;
  logic [V-1:0][N-1:0] Data_Mem_V_i;
  logic [V-1:0][N-1:0] Data_Result_V_i;
  logic [1:0]          OpType_i;
  logic                RegFile_WE_i;
  logic                WBSelect_i;
  logic                WE_S_o;
  logic [3:0]          A_S_o;
  logic [N-1:0]        WD_S_o;
  logic                WE_V_o;
  logic [3:0]          A_V_o;
  logic [BW-1:0]       Beat_V_o;
  logic [L-1:0][N-1:0] WD_V_o;
  logic                stall_o;
  logic                done_o;
  modport master (
    output A3_i, Data_Mem_S_i, Data_Result_S_i, Data_Mem_V_i, Data_Result_V_i,
           OpType_i, RegFile_WE_i, WBSelect_i,
    input  WE_S_o, A_S_o, WD_S_o, WE_V_o, A_V_o, Beat_V_o, WD_V_o, stall_o, done_o
  );
  modport slave (
    input  A3_i, Data_Mem_S_i, Data_Result_S_i, Data_Mem_V_i, Data_Result_V_i,
           OpType_i, RegFile_WE_i, WBSelect_i,
    output WE_S_o, A_S_o, WD_S_o, WE_V_o, A_V_o, Beat_V_o, WD_V_o, stall_o, done_o
  );
endinterface

// File: rtl/wb_lane_serializer.sv
// wb_lane_serializer: captures a vector result and streams it L lanes per beat
module wb_lane_serializer
  import wb_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int V  = 20,
  parameter  int L  = 4,
  localparam int B  = V / L,
  localparam int BW = B > 1 ? $clog2(B) : 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load_i,
  input  logic                busy_i,
  input  logic [3:0]          addr_i,
  input  logic [V-1:0][N-1:0] vec_i,
  output logic                we_o,
  output logic                last_o,
  output logic                done_o,
  output logic [3:0]          a_o,
  output logic [BW-1:0]       beat_o,
  output logic [L-1:0][N-1:0] wd_o
);
  logic [V-1:0][N-1:0] buf_q, buf_d;
  logic [3:0]          addr_q, addr_d;
  logic [BW-1:0]       beat_q, beat_d;
  assign last_o = beat_q == BW'(B - 1);
  always_comb begin
    buf_d  = load_i ? vec_i : buf_q;
    addr_d = load_i ? addr_i : addr_q;
    beat_d = (load_i || (busy_i && last_o)) ? '0 : busy_i ? beat_q + BW'(1) : beat_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_q  <= '0;
      addr_q <= '0;
      beat_q <= '0;
    end else begin
      buf_q  <= buf_d;
      addr_q <= addr_d;
      beat_q <= beat_d;
    end
  end
  // Outputs are forced to zero whenever no beat is being written
  assign we_o   = busy_i;
  assign done_o = busy_i && last_o;
  assign a_o    = busy_i ? addr_q : '0;
  assign beat_o = busy_i ? beat_q : '0;
  assign wd_o   = busy_i ? buf_q[lane_base(int'(beat_q), L) +: L] : '0;
endmodule

// File: rtl/wb_vector_writeback.sv
// wb_vector_writeback: writeback stage; one-cycle scalar RF write, multi-beat vector RF write with stall
module wb_vector_writeback
  import wb_pkg::*;
#(
  parameter int N = 32,
  parameter int V = 20,
  parameter int L = 4
) (
  input logic CLK,
  input logic RST,
  wb_vector_writeback_if.slave wb
);
  if (V % L != 0) begin : g_chk
    $error("wb_vector_writeback: V must be a multiple of L");
  end
  wb_state_t     state_q, state_d;
  logic          busy, is_vec, start, last;
  logic          we_s_q, we_s_d;
  logic [3:0]    a_s_q, a_s_d;
  logic [N-1:0]  wd_s_q, wd_s_d;
  assign busy   = state_q == WB_BUSY;
  assign is_vec = wb.OpType_i == OPTYPE_VECTOR;
  // Inputs are ignored while busy; upstream holds the next instruction
  always_comb begin
    start   = !busy && wb.RegFile_WE_i && is_vec;
    state_d = busy ? (last ? WB_IDLE : WB_BUSY) : (start ? WB_BUSY : WB_IDLE);
    we_s_d  = !busy && wb.RegFile_WE_i && !is_vec;
    a_s_d   = we_s_d ? wb.A3_i : '0;
    wd_s_d  = !we_s_d ? '0 : wb.WBSelect_i == WBSEL_MEM ? wb.Data_Mem_S_i : wb.Data_Result_S_i;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WB_IDLE;
      we_s_q  <= 1'b0;
      a_s_q   <= '0;
      wd_s_q  <= '0;
    end else begin
      state_q <= state_d;
      we_s_q  <= we_s_d;
      a_s_q   <= a_s_d;
      wd_s_q  <= wd_s_d;
    end
  end
  assign wb.WE_S_o  = we_s_q;
  assign wb.A_S_o   = a_s_q;
  assign wb.WD_S_o  = wd_s_q;
  assign wb.stall_o = busy;
  wb_lane_serializer #(.N(N), .V(V), .L(L)) u_ser (
    .CLK    (CLK),
    .RST    (RST),
    .load_i (start),
    .busy_i (busy),
    .addr_i (wb.A3_i),
    .vec_i  (wb.WBSelect_i == WBSEL_MEM ? wb.Data_Mem_V_i : wb.Data_Result_V_i),
    .we_o   (wb.WE_V_o),
    .last_o (last),
    .done_o (wb.done_o),
    .a_o    (wb.A_V_o),
    .beat_o (wb.Beat_V_o),
    .wd_o   (wb.WD_V_o)
  );
endmodule
